// File: rtl/bip_cpu_param.sv
// Parametrised single-accumulator BIP core.
// Executes one instruction per cycle from an external program memory against an
// external data memory. State (PC, ACC, HALTED) is registered; memory strobes,
// the DM address and the ZERO/NEG flags are decoded combinationally from the
// current instruction and accumulator.
module bip_cpu_param #(
    parameter int DATA_W    = 16,
    parameter int OPC_W     = 5,
    parameter int ADDR_PM_W = 11,
    parameter int ADDR_DM_W = 11,
    parameter bit SIGN_EXT  = 1'b0
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 EN,
    input  logic [DATA_W-1:0]    INSTRUCTION,
    input  logic [DATA_W-1:0]    DM_IN,
    output logic [ADDR_PM_W-1:0] ADDR_PM,
    output logic [ADDR_DM_W-1:0] ADDR_DM,
    output logic [DATA_W-1:0]    ACC,
    output logic                 RD,
    output logic                 WR,
    output logic                 ZERO,
    output logic                 NEG,
    output logic                 HALTED
);

    localparam int OPND_W = DATA_W - OPC_W;

    localparam logic [OPC_W-1:0] OP_HLT  = OPC_W'(0);
    localparam logic [OPC_W-1:0] OP_STO  = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_LD   = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_LDI  = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(6);
    localparam logic [OPC_W-1:0] OP_SUBI = OPC_W'(7);
    localparam logic [OPC_W-1:0] OP_AND  = OPC_W'(8);
    localparam logic [OPC_W-1:0] OP_ANDI = OPC_W'(9);
    localparam logic [OPC_W-1:0] OP_JMP  = OPC_W'(10);
    localparam logic [OPC_W-1:0] OP_BEQ  = OPC_W'(11);
    localparam logic [OPC_W-1:0] OP_BNE  = OPC_W'(12);

    logic [OPC_W-1:0]     opcode;
    logic [OPND_W-1:0]    operand;
    logic [DATA_W-1:0]    imm;
    logic [ADDR_PM_W-1:0] tgt;
    logic [ADDR_PM_W-1:0] pc_inc;
    logic                 exec;

    logic [DATA_W-1:0]    acc_next;
    logic [ADDR_PM_W-1:0] pc_next;
    logic                 halted_next;
    logic                 rd_dec;
    logic                 wr_dec;

    assign opcode  = INSTRUCTION[DATA_W-1 -: OPC_W];
    assign operand = INSTRUCTION[OPND_W-1:0];

    // Upper operand bits beyond the address widths are simply not wired.
    assign tgt     = operand[ADDR_PM_W-1:0];
    assign ADDR_DM = operand[ADDR_DM_W-1:0];
    assign pc_inc  = ADDR_PM + 1'b1;

    generate
        if (SIGN_EXT) begin : g_imm_sext
            assign imm = {{OPC_W{operand[OPND_W-1]}}, operand};
        end else begin : g_imm_zext
            assign imm = {{OPC_W{1'b0}}, operand};
        end
    endgenerate

    // RESET_N is folded in so the strobes drop the instant reset asserts.
    assign exec = EN & ~HALTED & RESET_N;
    assign RD   = exec & rd_dec;
    assign WR   = exec & wr_dec;
    assign ZERO = (ACC == '0);
    assign NEG  = ACC[DATA_W-1];

    // Decode the current instruction into next-state values and raw strobes.
    always_comb begin
        acc_next    = ACC;
        pc_next     = pc_inc;
        halted_next = HALTED;
        rd_dec      = 1'b0;
        wr_dec      = 1'b0;
        case (opcode)
            OP_HLT: begin
                halted_next = 1'b1;
                pc_next     = ADDR_PM;
            end
            OP_STO:  wr_dec = 1'b1;
            OP_LD: begin
                rd_dec   = 1'b1;
                acc_next = DM_IN;
            end
            OP_LDI:  acc_next = imm;
            OP_ADD: begin
                rd_dec   = 1'b1;
                acc_next = ACC + DM_IN;
            end
            OP_ADDI: acc_next = ACC + imm;
            OP_SUB: begin
                rd_dec   = 1'b1;
                acc_next = ACC - DM_IN;
            end
            OP_SUBI: acc_next = ACC - imm;
            OP_AND: begin
                rd_dec   = 1'b1;
                acc_next = ACC & DM_IN;
            end
            OP_ANDI: acc_next = ACC & imm;
            OP_JMP:  pc_next = tgt;
            // Branches look at the accumulator as it stands before this edge.
            OP_BEQ:  if (ZERO)  pc_next = tgt;
            OP_BNE:  if (!ZERO) pc_next = tgt;
            default: ;
        endcase
    end

    // Architectural state: cleared by reset, updated only on executing cycles.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ADDR_PM <= '0;
            ACC     <= '0;
            HALTED  <= 1'b0;
        end else if (exec) begin
            ADDR_PM <= pc_next;
            ACC     <= acc_next;
            HALTED  <= halted_next;
        end
    end

endmodule

// File: tb/tb_bip_cpu_param.sv
// Self-checking bench for bip_cpu_param: program-table stimulus with a
// scoreboard queue of expected post-edge state, plus hand-timed reset pulses.
module tb_bip_cpu_param;

    localparam logic [4:0] HLT  = 5'd0;
    localparam logic [4:0] STO  = 5'd1;
    localparam logic [4:0] LD   = 5'd2;
    localparam logic [4:0] LDI  = 5'd3;
    localparam logic [4:0] ADD  = 5'd4;
    localparam logic [4:0] ADDI = 5'd5;
    localparam logic [4:0] SUB  = 5'd6;
    localparam logic [4:0] SUBI = 5'd7;
    localparam logic [4:0] AND_ = 5'd8;
    localparam logic [4:0] ANDI = 5'd9;
    localparam logic [4:0] JMP  = 5'd10;
    localparam logic [4:0] BEQ  = 5'd11;
    localparam logic [4:0] BNE  = 5'd12;
    localparam logic [4:0] NOPA = 5'd15;
    localparam logic [4:0] NOPB = 5'd31;

    typedef struct packed {
        logic [15:0] ins;
        logic [15:0] dm;
        logic        en;
        logic [15:0] acc;
        logic [10:0] pc;
        logic        rd;
        logic        wr;
        logic        halted;
    } step_t;

    logic        CLK;
    logic        RESET_N;
    logic        EN;
    logic [15:0] INSTRUCTION;
    logic [15:0] DM_IN;

    logic [10:0] ADDR_PM, ADDR_DM;
    logic [15:0] ACC;
    logic        RD, WR, ZERO, NEG, HALTED;

    logic [10:0] s_addr_pm, s_addr_dm;
    logic [15:0] s_acc;
    logic        s_rd, s_wr, s_zero, s_neg, s_halted;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_count = 0;

    logic        rd_s, wr_s;
    logic [10:0] adm_s;

    step_t sb[$];

    bip_cpu_param dut (
        .CLK(CLK), .RESET_N(RESET_N), .EN(EN),
        .INSTRUCTION(INSTRUCTION), .DM_IN(DM_IN),
        .ADDR_PM(ADDR_PM), .ADDR_DM(ADDR_DM), .ACC(ACC),
        .RD(RD), .WR(WR), .ZERO(ZERO), .NEG(NEG), .HALTED(HALTED)
    );

    bip_cpu_param #(.SIGN_EXT(1'b1)) dut_s (
        .CLK(CLK), .RESET_N(RESET_N), .EN(EN),
        .INSTRUCTION(INSTRUCTION), .DM_IN(DM_IN),
        .ADDR_PM(s_addr_pm), .ADDR_DM(s_addr_dm), .ACC(s_acc),
        .RD(s_rd), .WR(s_wr), .ZERO(s_zero), .NEG(s_neg), .HALTED(s_halted)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Counts DM writes actually seen by memory at a rising edge.
    always @(posedge CLK) if (WR === 1'b1) wr_count <= wr_count + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] ins(input logic [4:0] op, input logic [10:0] opd);
        return {op, opd};
    endfunction

    function automatic step_t mk(input logic [15:0] i, input logic [15:0] d, input logic e,
                                 input logic [15:0] a, input logic [10:0] p,
                                 input logic r, input logic w, input logic h);
        step_t s;
        s.ins = i; s.dm = d; s.en = e; s.acc = a; s.pc = p; s.rd = r; s.wr = w; s.halted = h;
        return s;
    endfunction

    // Drive one instruction mid-cycle, sample combinational strobes, then take the edge.
    task automatic issue(input logic [15:0] i, input logic [15:0] d, input logic e);
        @(negedge CLK);
        INSTRUCTION = i;
        DM_IN       = d;
        EN          = e;
        #1;
        rd_s  = RD;
        wr_s  = WR;
        adm_s = ADDR_DM;
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        RESET_N     = 1'b0;
        EN          = 1'b1;
        INSTRUCTION = ins(NOPA, 11'd0);
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        INSTRUCTION = ins(LD, 11'd5);
        DM_IN       = 16'h1234;
        EN          = 1'b1;
        RESET_N     = 1'b0;
        #1;
        n_checks++;
        if ({ADDR_PM, ACC, HALTED} !== {11'd0, 16'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: pc=%h acc=%h halted=%b, expected pc=000 acc=0000 halted=0", ADDR_PM, ACC, HALTED);
        end
        n_checks++;
        if ({RD, WR, ZERO, NEG} !== 4'b0010) begin
            n_fail++;
            $display("FAIL reset_outputs: rd=%b wr=%b zero=%b neg=%b, expected 0 0 1 0", RD, WR, ZERO, NEG);
        end
        @(posedge CLK);
        #1;
        n_checks++;
        if ({ADDR_PM, ACC} !== {11'd0, 16'd0}) begin
            n_fail++;
            $display("FAIL reset_hold: pc=%h acc=%h, expected 000 0000", ADDR_PM, ACC);
        end
        RESET_N = 1'b1;
    endtask

    task automatic test_program();
        step_t tbl[9];
        step_t e;
        apply_reset();
        tbl[0] = mk(ins(LDI, 11'd4),    16'd0,  1, 16'd4,     11'd1, 0, 0, 0);
        tbl[1] = mk(ins(STO, 11'd2),    16'd0,  1, 16'd4,     11'd2, 0, 1, 0);
        tbl[2] = mk(ins(LD, 11'd2),     16'd10, 1, 16'd10,    11'd3, 1, 0, 0);
        tbl[3] = mk(ins(ADD, 11'd1),    16'd10, 1, 16'd20,    11'd4, 1, 0, 0);
        tbl[4] = mk(ins(ADDI, 11'd4),   16'd0,  1, 16'd24,    11'd5, 0, 0, 0);
        tbl[5] = mk(ins(SUBI, 11'd1),   16'd0,  1, 16'd23,    11'd6, 0, 0, 0);
        tbl[6] = mk(ins(AND_, 11'd3),   16'h0F, 1, 16'd7,     11'd7, 1, 0, 0);
        tbl[7] = mk(ins(ANDI, 11'h7F6), 16'd0,  1, 16'd6,     11'd8, 0, 0, 0);
        tbl[8] = mk(ins(SUB, 11'd5),    16'd10, 1, 16'hFFFC,  11'd9, 1, 0, 0);
        foreach (tbl[k]) begin
            sb.push_back(tbl[k]);
            issue(tbl[k].ins, tbl[k].dm, tbl[k].en);
            e = sb.pop_front();
            n_checks++;
            if ({ACC, ADDR_PM, rd_s, wr_s, HALTED} !== {e.acc, e.pc, e.rd, e.wr, e.halted}) begin
                n_fail++;
                $display("FAIL program[%0d]: acc=%h pc=%h rd=%b wr=%b halted=%b, expected acc=%h pc=%h rd=%b wr=%b halted=%b",
                         k, ACC, ADDR_PM, rd_s, wr_s, HALTED, e.acc, e.pc, e.rd, e.wr, e.halted);
            end
            if (e.rd || e.wr) begin
                n_checks++;
                if (adm_s !== e.ins[10:0]) begin
                    n_fail++;
                    $display("FAIL program_addr_dm[%0d]: addr_dm=%h, expected %h", k, adm_s, e.ins[10:0]);
                end
            end
        end
    endtask

    task automatic test_sign_ext();
        logic [15:0] op_tbl[3];
        logic [15:0] exp_z[3];
        logic [15:0] exp_s[3];
        apply_reset();
        op_tbl[0] = ins(LDI, 11'h7FF);  exp_z[0] = 16'h07FF; exp_s[0] = 16'hFFFF;
        op_tbl[1] = ins(ADDI, 11'h001); exp_z[1] = 16'h0800; exp_s[1] = 16'h0000;
        op_tbl[2] = ins(LDI, 11'h3FF);  exp_z[2] = 16'h03FF; exp_s[2] = 16'h03FF;
        foreach (op_tbl[k]) begin
            issue(op_tbl[k], 16'd0, 1'b1);
            n_checks++;
            if ({ACC, NEG, ZERO} !== {exp_z[k], exp_z[k][15], exp_z[k] == 16'd0}) begin
                n_fail++;
                $display("FAIL zext[%0d]: acc=%h neg=%b zero=%b, expected acc=%h", k, ACC, NEG, ZERO, exp_z[k]);
            end
            n_checks++;
            if ({s_acc, s_neg, s_zero} !== {exp_s[k], exp_s[k][15], exp_s[k] == 16'd0}) begin
                n_fail++;
                $display("FAIL sext[%0d]: acc=%h neg=%b zero=%b, expected acc=%h", k, s_acc, s_neg, s_zero, exp_s[k]);
            end
            n_checks++;
            if ({s_addr_pm, s_addr_dm, s_rd, s_wr, s_halted} !== {11'(k + 1), op_tbl[k][10:0], 3'b000}) begin
                n_fail++;
                $display("FAIL sext_misc[%0d]: pc=%h addr_dm=%h rd=%b wr=%b halted=%b, expected pc=%h addr_dm=%h 0 0 0",
                         k, s_addr_pm, s_addr_dm, s_rd, s_wr, s_halted, 11'(k + 1), op_tbl[k][10:0]);
            end
        end
    endtask

    task automatic test_branches();
        step_t tbl[12];
        step_t e;
        apply_reset();
        tbl[0]  = mk(ins(LDI, 11'd0),    0, 1, 16'd0, 11'd1,   0, 0, 0);
        tbl[1]  = mk(ins(BNE, 11'h020),  0, 1, 16'd0, 11'd2,   0, 0, 0);
        tbl[2]  = mk(ins(JMP, 11'd5),    0, 1, 16'd0, 11'd5,   0, 0, 0);
        tbl[3]  = mk(ins(BEQ, 11'h100),  0, 1, 16'd0, 11'h100, 0, 0, 0);
        tbl[4]  = mk(ins(LDI, 11'd3),    0, 1, 16'd3, 11'h101, 0, 0, 0);
        tbl[5]  = mk(ins(JMP, 11'd5),    0, 1, 16'd3, 11'd5,   0, 0, 0);
        tbl[6]  = mk(ins(BEQ, 11'h100),  0, 1, 16'd3, 11'd6,   0, 0, 0);
        tbl[7]  = mk(ins(JMP, 11'd5),    0, 1, 16'd3, 11'd5,   0, 0, 0);
        tbl[8]  = mk(ins(BNE, 11'h020),  0, 1, 16'd3, 11'h020, 0, 0, 0);
        tbl[9]  = mk(ins(JMP, 11'h7FF),  0, 1, 16'd3, 11'h7FF, 0, 0, 0);
        tbl[10] = mk(ins(NOPA, 11'd0),   0, 1, 16'd3, 11'd0,   0, 0, 0);
        tbl[11] = mk(ins(NOPB, 11'h7FF), 0, 1, 16'd3, 11'd1,   0, 0, 0);
        foreach (tbl[k]) begin
            sb.push_back(tbl[k]);
            issue(tbl[k].ins, tbl[k].dm, tbl[k].en);
            e = sb.pop_front();
            n_checks++;
            if ({ACC, ADDR_PM, rd_s, wr_s, HALTED} !== {e.acc, e.pc, e.rd, e.wr, e.halted}) begin
                n_fail++;
                $display("FAIL branch[%0d]: acc=%h pc=%h rd=%b wr=%b halted=%b, expected acc=%h pc=%h rd=%b wr=%b halted=%b",
                         k, ACC, ADDR_PM, rd_s, wr_s, HALTED, e.acc, e.pc, e.rd, e.wr, e.halted);
            end
        end
    endtask

    task automatic test_halt();
        step_t tbl[10];
        step_t e;
        apply_reset();
        tbl[0] = mk(ins(LDI, 11'd5), 0,     1, 16'd5, 11'd1, 0, 0, 0);
        tbl[1] = mk(ins(HLT, 11'd0), 0,     0, 16'd5, 11'd1, 0, 0, 0);
        tbl[2] = mk(ins(HLT, 11'd0), 0,     1, 16'd5, 11'd1, 0, 0, 1);
        tbl[3] = mk(ins(LDI, 11'd9), 0,     1, 16'd5, 11'd1, 0, 0, 1);
        tbl[4] = mk(ins(LDI, 11'd9), 0,     1, 16'd5, 11'd1, 0, 0, 1);
        tbl[5] = mk(ins(LDI, 11'd9), 0,     1, 16'd5, 11'd1, 0, 0, 1);
        tbl[6] = mk(ins(LDI, 11'd9), 0,     1, 16'd5, 11'd1, 0, 0, 1);
        tbl[7] = mk(ins(LDI, 11'd9), 0,     1, 16'd5, 11'd1, 0, 0, 1);
        tbl[8] = mk(ins(STO, 11'd2), 0,     1, 16'd5, 11'd1, 0, 0, 1);
        tbl[9] = mk(ins(LD, 11'd2),  16'd8, 1, 16'd5, 11'd1, 0, 0, 1);
        foreach (tbl[k]) begin
            sb.push_back(tbl[k]);
            issue(tbl[k].ins, tbl[k].dm, tbl[k].en);
            e = sb.pop_front();
            n_checks++;
            if ({ACC, ADDR_PM, rd_s, wr_s, HALTED} !== {e.acc, e.pc, e.rd, e.wr, e.halted}) begin
                n_fail++;
                $display("FAIL halt[%0d]: acc=%h pc=%h rd=%b wr=%b halted=%b, expected acc=%h pc=%h rd=%b wr=%b halted=%b",
                         k, ACC, ADDR_PM, rd_s, wr_s, HALTED, e.acc, e.pc, e.rd, e.wr, e.halted);
            end
        end
        // Asynchronous pulse entirely between two rising edges.
        @(negedge CLK);
        EN = 1'b0;
        #2 RESET_N = 1'b0;
        #1;
        n_checks++;
        if ({ADDR_PM, ACC, HALTED} !== {11'd0, 16'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL halt_async_reset: pc=%h acc=%h halted=%b, expected 000 0000 0", ADDR_PM, ACC, HALTED);
        end
        #1 RESET_N = 1'b1;
        @(posedge CLK);
        #1;
        n_checks++;
        if ({ADDR_PM, ACC, HALTED} !== {11'd0, 16'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL halt_after_pulse: pc=%h acc=%h halted=%b, expected 000 0000 0", ADDR_PM, ACC, HALTED);
        end
    endtask

    task automatic test_stall();
        step_t tbl[5];
        step_t e;
        int wr_start;
        apply_reset();
        wr_start = wr_count;
        tbl[0] = mk(ins(LDI, 11'd7), 0,     1, 16'd7,  11'd1, 0, 0, 0);
        tbl[1] = mk(ins(STO, 11'd3), 0,     0, 16'd7,  11'd1, 0, 0, 0);
        tbl[2] = mk(ins(ADD, 11'd1), 16'd5, 0, 16'd7,  11'd1, 0, 0, 0);
        tbl[3] = mk(ins(STO, 11'd3), 0,     1, 16'd7,  11'd2, 0, 1, 0);
        tbl[4] = mk(ins(ADD, 11'd1), 16'd5, 1, 16'd12, 11'd3, 1, 0, 0);
        foreach (tbl[k]) begin
            sb.push_back(tbl[k]);
            issue(tbl[k].ins, tbl[k].dm, tbl[k].en);
            e = sb.pop_front();
            n_checks++;
            if ({ACC, ADDR_PM, rd_s, wr_s, HALTED} !== {e.acc, e.pc, e.rd, e.wr, e.halted}) begin
                n_fail++;
                $display("FAIL stall[%0d]: acc=%h pc=%h rd=%b wr=%b halted=%b, expected acc=%h pc=%h rd=%b wr=%b halted=%b",
                         k, ACC, ADDR_PM, rd_s, wr_s, HALTED, e.acc, e.pc, e.rd, e.wr, e.halted);
            end
        end
        n_checks++;
        if (wr_count - wr_start !== 1) begin
            n_fail++;
            $display("FAIL stall_write_count: writes=%0d, expected 1", wr_count - wr_start);
        end
    endtask

    task automatic test_wrap_reset();
        int wr_before;
        apply_reset();
        issue(ins(LDI, 11'd0), 16'd0, 1'b1);
        issue(ins(SUBI, 11'd1), 16'd0, 1'b1);
        n_checks++;
        if ({ACC, ZERO, NEG, ADDR_PM} !== {16'hFFFF, 1'b0, 1'b1, 11'd2}) begin
            n_fail++;
            $display("FAIL wrap_subi: acc=%h zero=%b neg=%b pc=%h, expected FFFF 0 1 002", ACC, ZERO, NEG, ADDR_PM);
        end
        @(negedge CLK);
        INSTRUCTION = ins(STO, 11'd4);
        EN          = 1'b1;
        #1;
        n_checks++;
        if (WR !== 1'b1) begin
            n_fail++;
            $display("FAIL midop_wr_before: wr=%b, expected 1", WR);
        end
        #1;
        wr_before = wr_count;
        RESET_N   = 1'b0;
        #1;
        n_checks++;
        if ({WR, ACC, ADDR_PM} !== {1'b0, 16'd0, 11'd0}) begin
            n_fail++;
            $display("FAIL midop_reset: wr=%b acc=%h pc=%h, expected 0 0000 000", WR, ACC, ADDR_PM);
        end
        @(posedge CLK);
        #1;
        n_checks++;
        if (wr_count !== wr_before) begin
            n_fail++;
            $display("FAIL midop_no_write: writes=%0d, expected %0d", wr_count, wr_before);
        end
        RESET_N = 1'b1;
    endtask

    initial begin
        RESET_N     = 1'b0;
        EN          = 1'b0;
        INSTRUCTION = 16'd0;
        DM_IN       = 16'd0;
        rd_s        = 1'b0;
        wr_s        = 1'b0;
        adm_s       = 11'd0;
        test_reset();
        test_program();
        test_sign_ext();
        test_branches();
        test_halt();
        test_stall();
        test_wrap_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
